up_down_count_monitor: RTL and testbench
========================================

Name: up_down_count_monitor

Overview:
Downstream observer of the up/down counter. Samples the counter's direction input `d` and its `count` output every clock and reports:
- wrap-around events (up and down)
- step-consistency errors
- a running peak value
- a hysteresis alarm with a hold filter

All results are registered for status/debug logic. The block never drives the counter.

Parameters:
- CNT_W, 4, width of the observed count.
- HI_TH, 12, alarm arm threshold (count >= HI_TH).
- LO_TH, 3, alarm release threshold (count <= LO_TH); requires LO_TH < HI_TH.
- HOLD, 2, consecutive cycles at or above HI_TH before alarm asserts (>= 1).
- WRAP_W, 8, width of the saturating wrap event counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- d  in  1  counter direction (1 = up, 0 = down), as driven into the counter.
- count  in  CNT_W  counter output.
- clr  in  1  synchronous clear of peak, wrap_cnt and step_err_sticky; alarm FSM unaffected.
- wrap_up  out  1  one-cycle pulse: up wrap detected.
- wrap_dn  out  1  one-cycle pulse: down wrap detected.
- wrap_cnt  out  WRAP_W  saturating count of wrap events (up + down).
- step_err  out  1  one-cycle pulse: count did not move by exactly one step.
- step_err_sticky  out  1  latched step_err until clr/rst.
- peak  out  CNT_W  maximum count sampled since rst/clr.
- alarm  out  1  hysteresis alarm level.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high; ports are named `clk` and `rst`.
- Reset values: every output is 0, and all internal state is cleared:
  - prev_valid = 0, prev_cnt = 0, prev_d = 0
  - FSM = IDLE, hold_cnt = 0
- Reset mid-operation behaves identically to the first reset. The first sample after reset only loads prev_cnt/prev_d and sets prev_valid; no flags are raised that cycle.
- Sampling: every cycle, prev_cnt <= count and prev_d <= d. The step seen on `count` at cycle k was caused by `d` at k-1, so expected = prev_d ? prev_cnt+1 : prev_cnt-1, taken modulo 2^CNT_W.
- All outputs are registered. Latency is 1 cycle from the sample exhibiting the event to the output.
- wrap_up is asserted when prev_valid && prev_d && prev_cnt == all-ones && count == 0.
- wrap_dn is asserted when prev_valid && !prev_d && prev_cnt == 0 && count == all-ones.
- wrap_up and wrap_dn are mutually exclusive by construction.
- wrap_cnt increments on either pulse and saturates at 2^WRAP_W-1 (no roll-over).
- step_err is asserted when prev_valid && count != expected. A held value (count == prev_cnt) is also an error.
- step_err_sticky is set by step_err. If clr and step_err occur in the same cycle, set wins.
- peak <= max(peak, count) each cycle. On clr, peak <= count (the current sample), not 0.
- If clr coincides with a wrap, wrap_cnt loads 1.
- Alarm FSM (hold_cnt width is clog2(HOLD+1)):
  - IDLE: if count >= HI_TH, go to ARMING with hold_cnt = 1; if additionally HOLD == 1, go directly to ALARM.
  - ARMING: if count >= HI_TH, increment hold_cnt; go to ALARM when hold_cnt reaches HOLD; if count < HI_TH, return to IDLE and clear hold_cnt.
  - ALARM: alarm = 1; go to IDLE only when count <= LO_TH. Values strictly between LO_TH and HI_TH keep ALARM.
  - alarm is the registered decode of state == ALARM.
- Arithmetic: all compares are unsigned on CNT_W bits. Expected-value math is done in CNT_W bits so that wrap-around is natural.

Decomposition:
- Package `up_down_mon_pkg`:
  - alarm state enum `mon_state_e` {IDLE, ARMING, ALARM}
  - function `exp_next(cnt, dir)` for the expected-step calculation, reused by the bench scoreboard
- Sub-module `sat_counter` (parameter W; inputs inc, clr_load; output value) implements wrap_cnt. Everything else lives in the top module.

Test Plan:
- Run all scenarios with CNT_W=4, HI_TH=12, LO_TH=3, HOLD=2.
- 1. rst=1 for 2 cycles, then count = 0,1,2 with d=1 -> all outputs 0 during reset; no step_err on the first post-reset sample; peak = 2.
- 2. d=1, count runs 13,14,15,0,1 -> wrap_up pulses exactly one cycle after the sample 0; wrap_cnt = 1; step_err never asserted.
- 3. d=0, count runs 2,1,0,15,14 -> wrap_dn pulses once; wrap_cnt increments; alarm asserts two cycles after the first sample >= 12 (samples 15,14 satisfy HOLD=2).
- 4. Alarm hysteresis: with alarm=1, count falls 11..4 -> alarm stays 1; at sample 3 -> alarm drops the next cycle. Separately, a single sample of 12 followed by 11 -> alarm never asserts.
- 5. Inject count 5 then 9 (d=1) -> step_err pulses once and step_err_sticky = 1; clr in the next cycle -> sticky = 0, peak = current count, wrap_cnt = 0.
- 6. Force 300 up wraps with WRAP_W=8 -> wrap_cnt saturates at 255. Assert rst mid-run -> all outputs 0 on the next cycle and the FSM is in IDLE.

Source files
------------

// File: rtl/up_down_count_monitor_pkg.sv
// Shared types and helpers for the up/down counter monitor.
//   mon_state_e : hysteresis alarm state (IDLE, ARMING, ALARM)
//   exp_next    : expected count after one step of a w-bit up/down counter
package up_down_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    ALARM
  } mon_state_e;

  // One step in direction dir (1 = up), wrapping modulo 2^w.
  function automatic logic [31:0] exp_next(input logic [31:0] cnt,
                                           input logic        dir,
                                           input int unsigned w);
    logic [31:0] mask;
    logic [31:0] nxt;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    nxt  = dir ? (cnt + 32'd1) : (cnt - 32'd1);
    return nxt & mask;
  endfunction

endpackage

// File: rtl/up_down_count_monitor_sat_counter.sv
// Saturating event counter.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : count one event this cycle
//   clr_load  : restart the count; an event in the same cycle is kept (loads 1)
//   value     : current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr_load,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (clr_load) begin
      value <= inc ? W'(1) : '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/up_down_count_monitor.sv
// Passive observer of an up/down counter. Samples direction d and count
// every clock and reports registered status (1-cycle latency):
//   clk, rst        : clock, synchronous active-high reset
//   d, count        : counter direction (1 = up) and counter value
//   clr             : clears peak, wrap_cnt and step_err_sticky
//   wrap_up/wrap_dn : one-cycle pulses on an up / down wrap
//   wrap_cnt        : saturating number of wraps
//   step_err        : pulse when count did not move by exactly one step
//   step_err_sticky : latched step_err
//   peak            : maximum count since rst/clr
//   alarm           : hysteresis alarm (arm >= HI_TH for HOLD samples, release <= LO_TH)
module up_down_count_monitor
  import up_down_mon_pkg::*;
#(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned HI_TH  = 12,
  parameter int unsigned LO_TH  = 3,
  parameter int unsigned HOLD   = 2,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  input  logic [CNT_W-1:0]  count,
  input  logic              clr,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              step_err,
  output logic              step_err_sticky,
  output logic [CNT_W-1:0]  peak,
  output logic              alarm
);

  localparam int unsigned HW = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] HI_C   = CNT_W'(HI_TH);
  localparam logic [CNT_W-1:0] LO_C   = CNT_W'(LO_TH);
  localparam logic [HW-1:0]    HOLD_C = HW'(HOLD);

  logic             prev_valid;
  logic [CNT_W-1:0] prev_cnt;
  logic             prev_d;

  mon_state_e       state, state_next;
  logic [HW-1:0]    hold_cnt, hold_next;

  logic [CNT_W-1:0] expected;
  logic             wrap_up_nxt, wrap_dn_nxt, step_err_nxt;
  logic [CNT_W-1:0] peak_nxt;

  // Event detection on the current sample against the previous one.
  always_comb begin
    expected     = CNT_W'(exp_next(32'(prev_cnt), prev_d, CNT_W));
    wrap_up_nxt  = prev_valid && prev_d && (prev_cnt == '1) && (count == '0);
    wrap_dn_nxt  = prev_valid && !prev_d && (prev_cnt == '0) && (count == '1);
    step_err_nxt = prev_valid && (count != expected);
    if (clr) begin
      peak_nxt = count;
    end else begin
      peak_nxt = (count > peak) ? count : peak;
    end
  end

  // Alarm FSM next state. hold_cnt counts consecutive samples >= HI_TH and
  // the transition to ALARM happens on the sample that makes it reach HOLD.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      IDLE: begin
        if (count >= HI_C) begin
          if (HOLD == 1) begin
            state_next = ALARM;
            hold_next  = '0;
          end else begin
            state_next = ARMING;
            hold_next  = HW'(1);
          end
        end
      end
      ARMING: begin
        if (count >= HI_C) begin
          hold_next = hold_cnt + HW'(1);
          if (hold_next == HOLD_C) begin
            state_next = ALARM;
            hold_next  = '0;
          end
        end else begin
          state_next = IDLE;
          hold_next  = '0;
        end
      end
      ALARM: begin
        if (count <= LO_C) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid      <= 1'b0;
      prev_cnt        <= '0;
      prev_d          <= 1'b0;
      wrap_up         <= 1'b0;
      wrap_dn         <= 1'b0;
      step_err        <= 1'b0;
      step_err_sticky <= 1'b0;
      peak            <= '0;
      state           <= IDLE;
      hold_cnt        <= '0;
      alarm           <= 1'b0;
    end else begin
      prev_valid      <= 1'b1;
      prev_cnt        <= count;
      prev_d          <= d;
      wrap_up         <= wrap_up_nxt;
      wrap_dn         <= wrap_dn_nxt;
      step_err        <= step_err_nxt;
      // A new error wins over a simultaneous clear.
      step_err_sticky <= step_err_nxt | (step_err_sticky & ~clr);
      peak            <= peak_nxt;
      state           <= state_next;
      hold_cnt        <= hold_next;
      // Decoded from the next state so alarm lines up with the state register.
      alarm           <= (state_next == ALARM);
    end
  end

  sat_counter #(
    .W(WRAP_W)
  ) u_wrap_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (wrap_up_nxt | wrap_dn_nxt),
    .clr_load (clr),
    .value    (wrap_cnt)
  );

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Self-checking bench for up_down_count_monitor: hand-derived vector table,
// counter-saturation / mid-run reset sequence, and randomized stimulus
// against a behavioural reference model.
module tb_up_down_count_monitor;
  import up_down_mon_pkg::*;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HI_TH  = 12;
  localparam int unsigned LO_TH  = 3;
  localparam int unsigned HOLD   = 2;
  localparam int unsigned WRAP_W = 8;
  localparam int MOD  = 1 << CNT_W;
  localparam int WMAX = (1 << WRAP_W) - 1;

  logic              clk = 1'b0;
  logic              rst, d, clr;
  logic [CNT_W-1:0]  count;
  logic              wrap_up, wrap_dn, step_err, step_err_sticky, alarm;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [CNT_W-1:0]  peak;

  up_down_count_monitor #(
    .CNT_W (CNT_W),
    .HI_TH (HI_TH),
    .LO_TH (LO_TH),
    .HOLD  (HOLD),
    .WRAP_W(WRAP_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .d              (d),
    .count          (count),
    .clr            (clr),
    .wrap_up        (wrap_up),
    .wrap_dn        (wrap_dn),
    .wrap_cnt       (wrap_cnt),
    .step_err       (step_err),
    .step_err_sticky(step_err_sticky),
    .peak           (peak),
    .alarm          (alarm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: previous sample, running maxima and counts,
  // and the length of the current run of samples at or above HI_TH.
  bit m_valid, m_pd, m_sticky, m_alarm;
  int m_pcnt, m_peak, m_wc, m_run;
  bit e_wu, e_wd, e_se;

  typedef struct {
    bit r; bit dv; int c; bit cl;
    bit wu; bit wd; bit se; bit st; int pk; bit al; int wc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(bit r, bit dv, int c, bit cl, bit wu, bit wd,
                             bit se, bit st, int pk, bit al, int wc);
    vec_t x;
    x.r = r; x.dv = dv; x.c = c; x.cl = cl;
    x.wu = wu; x.wd = wd; x.se = se; x.st = st; x.pk = pk; x.al = al; x.wc = wc;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit dv, input int c, input bit cl);
    if (r) begin
      m_valid = 0; m_pd = 0; m_pcnt = 0; m_peak = 0; m_wc = 0; m_run = 0;
      m_sticky = 0; m_alarm = 0; e_wu = 0; e_wd = 0; e_se = 0;
    end else begin
      e_wu = m_valid && m_pd && (m_pcnt == MOD - 1) && (c == 0);
      e_wd = m_valid && !m_pd && (m_pcnt == 0) && (c == MOD - 1);
      e_se = m_valid && (c != ((m_pcnt + (m_pd ? 1 : -1) + MOD) % MOD));
      if (cl) m_wc = (e_wu || e_wd) ? 1 : 0;
      else if (e_wu || e_wd) m_wc = (m_wc < WMAX) ? m_wc + 1 : WMAX;
      if (e_se) m_sticky = 1;
      else if (cl) m_sticky = 0;
      m_peak = cl ? c : ((c > m_peak) ? c : m_peak);
      m_run = (c >= int'(HI_TH)) ? m_run + 1 : 0;
      if (m_alarm) begin
        if (c <= int'(LO_TH)) m_alarm = 0;
      end else if (m_run >= int'(HOLD)) begin
        m_alarm = 1;
      end
      m_valid = 1; m_pcnt = c; m_pd = dv;
    end
  endtask

  task automatic drive(input bit r, input bit dv, input int c, input bit cl);
    rst = r; d = dv; count = CNT_W'(c); clr = cl;
    @(posedge clk);
    #1;
    model_step(r, dv, c, cl);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".wrap_up"},  int'(wrap_up),         int'(e_wu));
    check({tag, ".wrap_dn"},  int'(wrap_dn),         int'(e_wd));
    check({tag, ".step_err"}, int'(step_err),        int'(e_se));
    check({tag, ".sticky"},   int'(step_err_sticky), int'(m_sticky));
    check({tag, ".peak"},     int'(peak),            m_peak);
    check({tag, ".alarm"},    int'(alarm),           int'(m_alarm));
    check({tag, ".wrap_cnt"}, int'(wrap_cnt),        m_wc);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur, pd, nc;
    bit r, dv, cl;
    rst = 1'b1; d = 1'b0; count = '0; clr = 1'b0;

    //                r  d  c  cl   wu wd se st pk al wc
    // reset, then 0,1,2 counting up
    tbl.push_back(v(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0,  0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 2, 0,  0, 0, 0, 0, 2, 0, 0));
    // up wrap 13,14,15,0,1 (alarm arms on 13,14, releases on 0)
    tbl.push_back(v(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 13, 0, 0, 0, 0, 0, 13, 0, 0));
    tbl.push_back(v(0, 1, 14, 0, 0, 0, 0, 0, 14, 1, 0));
    tbl.push_back(v(0, 1, 15, 0, 0, 0, 0, 0, 15, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  1, 0, 0, 0, 15, 0, 1));
    tbl.push_back(v(0, 1, 1, 0,  0, 0, 0, 0, 15, 0, 1));
    // down wrap 2,1,0,15,14; alarm after 15,14
    tbl.push_back(v(0, 0, 2, 0,  0, 0, 0, 0, 15, 0, 1));
    tbl.push_back(v(0, 0, 1, 0,  0, 0, 0, 0, 15, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,  0, 0, 0, 0, 15, 0, 1));
    tbl.push_back(v(0, 0, 15, 0, 0, 1, 0, 0, 15, 0, 2));
    tbl.push_back(v(0, 0, 14, 0, 0, 0, 0, 0, 15, 1, 2));
    // hysteresis: 13 down to 4 keeps alarm, 3 releases it
    for (int c = 13; c >= 4; c--) tbl.push_back(v(0, 0, c, 0, 0, 0, 0, 0, 15, 1, 2));
    tbl.push_back(v(0, 0, 3, 0,  0, 0, 0, 0, 15, 0, 2));
    // single sample of 12 then 11: no alarm
    tbl.push_back(v(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 12, 0, 0, 0, 0, 0, 12, 0, 0));
    tbl.push_back(v(0, 0, 11, 0, 0, 0, 0, 0, 12, 0, 0));
    tbl.push_back(v(0, 0, 10, 0, 0, 0, 0, 0, 12, 0, 0));
    // wrap, then 5 -> 9 step error, then clr
    tbl.push_back(v(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 15, 0, 0, 0, 0, 0, 15, 0, 0));
    tbl.push_back(v(0, 1, 0, 0,  1, 0, 0, 0, 15, 0, 1));
    for (int c = 1; c <= 5; c++) tbl.push_back(v(0, 1, c, 0, 0, 0, 0, 0, 15, 0, 1));
    tbl.push_back(v(0, 1, 9, 0,  0, 0, 1, 1, 15, 0, 1));
    tbl.push_back(v(0, 1, 10, 1, 0, 0, 0, 0, 10, 0, 0));
    tbl.push_back(v(0, 1, 11, 0, 0, 0, 0, 0, 11, 0, 0));
    tbl.push_back(v(0, 1, 12, 0, 0, 0, 0, 0, 12, 0, 0));
    tbl.push_back(v(0, 1, 13, 0, 0, 0, 0, 0, 13, 1, 0));
    tbl.push_back(v(0, 1, 14, 0, 0, 0, 0, 0, 14, 1, 0));
    tbl.push_back(v(0, 1, 15, 0, 0, 0, 0, 0, 15, 1, 0));
    // clr with wrap loads 1; clr with step error keeps sticky set
    tbl.push_back(v(0, 1, 0, 1,  1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 5, 1,  0, 0, 1, 1, 5, 0, 0));
    tbl.push_back(v(0, 1, 6, 0,  0, 0, 0, 1, 6, 0, 0));
    // held value is an error
    tbl.push_back(v(0, 1, 6, 0,  0, 0, 1, 1, 6, 0, 0));
    // mid-run reset, first sample raises nothing
    tbl.push_back(v(1, 1, 6, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 7, 0,  0, 0, 0, 0, 7, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].dv, tbl[i].c, tbl[i].cl);
      check($sformatf("vec%0d.wrap_up", i),  int'(wrap_up),         int'(tbl[i].wu));
      check($sformatf("vec%0d.wrap_dn", i),  int'(wrap_dn),         int'(tbl[i].wd));
      check($sformatf("vec%0d.step_err", i), int'(step_err),        int'(tbl[i].se));
      check($sformatf("vec%0d.sticky", i),   int'(step_err_sticky), int'(tbl[i].st));
      check($sformatf("vec%0d.peak", i),     int'(peak),            tbl[i].pk);
      check($sformatf("vec%0d.alarm", i),    int'(alarm),           int'(tbl[i].al));
      check($sformatf("vec%0d.wrap_cnt", i), int'(wrap_cnt),        tbl[i].wc);
    end

    // 300 up wraps: wrap_cnt must stick at 255
    drive(1, 0, 0, 0);
    for (int i = 0; i <= 300 * MOD; i++) begin
      drive(0, 1, i % MOD, 0);
      check_model("sat");
    end
    check("sat.final_wrap_cnt", int'(wrap_cnt), 255);
    // mid-run reset clears everything and parks the FSM in IDLE
    drive(0, 1, 1, 0);
    drive(0, 1, 2, 0);
    drive(1, 1, 3, 0);
    check_model("midrst");
    check("midrst.fsm_idle", int'(dut.state), int'(IDLE));

    // randomized walk with occasional jumps, holds, clears and resets
    cur = 0; pd = 1;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      cl = ($urandom_range(0, 24) == 0);
      dv = ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 19) == 0) nc = int'($urandom_range(0, MOD - 1));
      else nc = (cur + (pd != 0 ? 1 : MOD - 1)) % MOD;
      drive(r, dv, nc, cl);
      check_model($sformatf("rnd%0d", i));
      cur = nc; pd = int'(dv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
